mem_subsystem: RTL and testbench

- Parametrised successor to the core's data/program memory block: one data memory and one program memory.
- Data port uses a valid/ready request interface with a registered, 1-cycle read response. Instruction fetch is registered.
- After reset, a hardware clear sequence zeroes data memory. Software can re-trigger the clear.
- Program memory is loaded through a write port, not a simulation file, so the block is usable on hardware.

---
 rtl/mem_subsystem_if.sv | 63 ++++++
 rtl/mem_subsystem.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_subsystem.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_subsystem_if.sv
// mem_subsystem_if / mem_subsystem_pkg
//
// Purpose:
//   mem_subsystem_pkg holds the data-port operation encoding.
//   mem_subsystem_if groups the data-port request/response handshake of
//   mem_subsystem.
//
// Signals:
//   req_valid  requester -> memory  request present
//   req_ready  memory -> requester  request can be accepted this cycle
//   req_op     requester -> memory  MEM_READ / MEM_WRITE, other codes no-op
//   req_addr   requester -> memory  data word address
//   req_wdata  requester -> memory  write data
//   rsp_valid  memory -> requester  one-cycle pulse, rsp_rdata valid
//   rsp_rdata  memory -> requester  read data
//
// Modports: master (requester side), slave (memory side).

package mem_subsystem_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_op_e;

endpackage

interface mem_subsystem_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_op,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/mem_subsystem.sv
// mem_subsystem
//
// Purpose:
//   Data memory with a valid/ready request port and a registered 1-cycle
//   read response, plus a program memory with a registered instruction
//   fetch and a write-only load port. After reset (and on clear_start) a
//   hardware sequence zeroes the whole data memory, one word per cycle.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        asynchronous, active-low reset
//   bus          mem_subsystem_if.slave data request/response port
//   clear_start  request a data-memory clear (honoured in IDLE only)
//   busy         clear in progress
//   pc           fetch address
//   instr        instruction at the pc of the previous cycle
//   load_en      program memory write strobe
//   load_addr    program write address
//   load_data    program write data
//   addr_err     one-cycle out-of-range pulse
//
// Optional feature:
//   MEM_SUBSYSTEM_BOUNDS_CHECK_EN - when defined, addr_err pulses the cycle
//   after an accepted out-of-range read/write, an out-of-range pc fetch or an
//   out-of-range load. When undefined, addr_err is tied to 0.

module mem_subsystem #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA_DEPTH  = 256,
    parameter int INSTR_WIDTH = 40,
    parameter int PROG_DEPTH  = 256,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_subsystem_if.slave         bus,
    input  logic                   clear_start,
    output logic                   busy,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic [INSTR_WIDTH-1:0] instr,
    input  logic                   load_en,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic                   addr_err
);

    import mem_subsystem_pkg::*;

    localparam int DA_W = $clog2(DATA_DEPTH);
    localparam int PA_W = $clog2(PROG_DEPTH);

    localparam logic [ADDR_WIDTH:0] DATA_LIMIT = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH:0] PROG_LIMIT = (ADDR_WIDTH+1)'(PROG_DEPTH);
    localparam logic [DA_W-1:0]     CLEAR_LAST = DA_W'(DATA_DEPTH - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Storage (not reset; the clear sequence initialises data memory)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  data_mem [DATA_DEPTH];
    logic [INSTR_WIDTH-1:0] prog_mem [PROG_DEPTH];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q,     state_d;
    logic [DA_W-1:0]        clear_ptr_q, clear_ptr_d;
    logic                   req_ready_q, req_ready_d;
    logic                   busy_q,      busy_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [INSTR_WIDTH-1:0] instr_q,     instr_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            accept;
    logic            is_read;
    logic            is_write;
    logic            req_in_range;
    logic [DA_W-1:0] req_idx;

    assign accept       = bus.req_valid && req_ready_q;
    assign is_read      = (bus.req_op == MEM_READ);
    assign is_write     = (bus.req_op == MEM_WRITE);
    // Compare on the full address width so out-of-range addresses are
    // never aliased onto a valid word.
    assign req_in_range = ({1'b0, bus.req_addr} < DATA_LIMIT);
    assign req_idx      = bus.req_addr[DA_W-1:0];

    logic            pc_in_range;
    logic            load_in_range;
    logic [PA_W-1:0] pc_idx;
    logic [PA_W-1:0] load_idx;

    assign pc_in_range   = ({1'b0, pc} < PROG_LIMIT);
    assign load_in_range = ({1'b0, load_addr} < PROG_LIMIT);
    assign pc_idx        = pc[PA_W-1:0];
    assign load_idx      = load_addr[PA_W-1:0];

    // ------------------------------------------------------------------
    // Data memory write port: either the clear sequence or an accepted
    // write. They never coincide since req_ready is only high in IDLE.
    // ------------------------------------------------------------------
    logic                  dmem_we;
    logic [DA_W-1:0]       dmem_waddr;
    logic [DATA_WIDTH-1:0] dmem_wdata;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        dmem_we     = 1'b0;
        dmem_waddr  = req_idx;
        dmem_wdata  = bus.req_wdata;

        case (state_q)
            CLEAR: begin
                dmem_we    = 1'b1;
                dmem_waddr = clear_ptr_q;
                dmem_wdata = '0;
                if (clear_ptr_q == CLEAR_LAST) begin
                    state_d     = IDLE;
                    clear_ptr_d = '0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    clear_ptr_d = clear_ptr_q + DA_W'(1);
                end
            end

            IDLE: begin
                if (clear_start) begin
                    state_d     = CLEAR;
                    clear_ptr_d = '0;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
                // Uses the current req_ready, so a request coinciding with
                // clear_start is still served.
                if (accept) begin
                    if (is_write && req_in_range) begin
                        dmem_we = 1'b1;
                    end
                    if (is_read) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = req_in_range ? data_mem[req_idx] : '0;
                    end
                end
            end

            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Fetch reads the array before this edge's load lands (read-before-write).
    always_comb begin
        instr_d = pc_in_range ? prog_mem[pc_idx] : '0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            instr_q     <= instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            data_mem[dmem_waddr] <= dmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            prog_mem[load_idx] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Bounds reporting
    // ------------------------------------------------------------------
`ifdef MEM_SUBSYSTEM_BOUNDS_CHECK_EN
    logic addr_err_q, addr_err_d;

    always_comb begin
        addr_err_d = (accept && (is_read || is_write) && !req_in_range)
                   || !pc_in_range
                   || (load_en && !load_in_range);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy          = busy_q;
    assign instr         = instr_q;

endmodule

// File: tb/tb_mem_subsystem.sv
// tb_mem_subsystem
//
// Self-checking bench for mem_subsystem. Reads are scored through a queue of
// expected {data, response cycle} entries; addr_err is compared every cycle
// against a set of cycles where a pulse is expected (only when
// MEM_SUBSYSTEM_BOUNDS_CHECK_EN is defined, otherwise it must stay 0).

module tb_mem_subsystem;

    import mem_subsystem_pkg::*;

    localparam int DW = 16;
    localparam int DD = 256;
    localparam int IW = 40;
    localparam int PD = 256;
    localparam int AW = 16;

`ifdef MEM_SUBSYSTEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear_start = 1'b0;
    logic          busy;
    logic [AW-1:0] pc = '0;
    logic [IW-1:0] instr;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          addr_err;

    mem_subsystem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_subsystem #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DD),
        .INSTR_WIDTH(IW),
        .PROG_DEPTH (PD),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .clear_start(clear_start),
        .busy       (busy),
        .pc         (pc),
        .instr      (instr),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } rsp_t;

    rsp_t          sb[$];
    bit            err_at[int unsigned];
    logic [DW-1:0] model [DD];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Response / addr_err monitor
    always @(negedge clk) begin
        rsp_t it;
        if (!reset) begin
            sb.delete();
        end else begin
            check("addr_err", addr_err, (BOUNDS && err_at.exists(cyc)) ? 1 : 0);
            if (bus.rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    it = sb.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, it.data);
                    check("rsp_cycle", cyc, it.cyc);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int unsigned w = 0;
        bit          oor;
        rsp_t        it;
        oor           = (int'(addr) >= DD);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && w < 2000) begin
            w++;
            @(negedge clk);
        end
        if (bus.req_ready !== 1'b1) begin
            check("accept_timeout", 0, 1);
        end else begin
            if (op == MEM_READ) begin
                it.data = oor ? '0 : model[addr[7:0]];
                it.cyc  = cyc + 1;
                sb.push_back(it);
                if (oor) err_at[cyc + 1] = 1'b1;
            end else if (op == MEM_WRITE) begin
                if (!oor) model[addr[7:0]] = wd;
                else      err_at[cyc + 1] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic zero_model();
        for (int i = 0; i < DD; i++) model[i] = '0;
    endtask

    // Counts cycles with busy high; called at posedge+1.
    task automatic wait_clear(input string tag);
        int unsigned n   = 0;
        int unsigned bad = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 2000) begin
            n++;
            if (bus.req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        check({tag, "_len"}, n, 256);
        check({tag, "_ready_low"}, bad, 0);
        check({tag, "_ready_after"}, bus.req_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic read_all();
        for (int i = 0; i < DD; i++) send(MEM_READ, AW'(i), '0);
    endtask

    task automatic drain(input string tag);
        int unsigned w = 0;
        while (sb.size() != 0 && w < 10) begin
            w++;
            @(posedge clk);
        end
        #1;
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = MEM_NOP;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_instr", instr, 0);
        check("rst_addr_err", addr_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        zero_model();
        wait_clear("por");
        read_all();
        drain("por");

        // Write then read next cycle
        send(MEM_WRITE, 16'd5, 16'hBEEF);
        send(MEM_READ, 16'd5, '0);
        // Back-to-back reads
        send(MEM_WRITE, 16'd1, 16'd10);
        send(MEM_WRITE, 16'd2, 16'd20);
        send(MEM_WRITE, 16'd3, 16'd30);
        send(MEM_READ, 16'd1, '0);
        send(MEM_READ, 16'd2, '0);
        send(MEM_READ, 16'd3, '0);
        // Top word, no wrap past the end, no-op code
        send(MEM_WRITE, 16'd255, 16'hA5A5);
        send(MEM_WRITE, 16'd0, 16'h0F0F);
        send(MEM_WRITE, 16'd256, 16'hDEAD);
        send(MEM_READ, 16'd255, '0);
        send(MEM_READ, 16'd0, '0);
        send(MEM_READ, 16'd256, '0);
        send(MEM_WRITE, 16'd20, 16'h4242);
        send(MEM_RSVD, 16'd20, 16'h9999);
        send(MEM_NOP, 16'd20, 16'h8888);
        send(MEM_READ, 16'd20, '0);
        // Out-of-range write dropped (300 would alias 44 if wrapped)
        send(MEM_WRITE, 16'd44, 16'h1111);
        send(MEM_WRITE, 16'd300, 16'h7777);
        send(MEM_READ, 16'd300, '0);
        send(MEM_READ, 16'd44, '0);
        drain("rw");

        // Program load, read-before-write on the fetch
        load_en = 1'b1; load_addr = 16'd7; load_data = 40'h11_1111_1111; pc = 16'd3;
        @(posedge clk); #1;
        load_en = 1'b0; pc = 16'd7;
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = 16'd7; load_data = 40'h01_0203_0405;
        @(posedge clk);
        @(negedge clk);
        check("load_rbw_old", instr, 40'h11_1111_1111);
        load_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("load_rbw_new", instr, 40'h01_0203_0405);
        @(posedge clk); #1;

        // Out-of-range fetch
        pc = 16'd300;
        err_at[cyc + 1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pc_oor_instr", instr, 0);
        pc = 16'd7;
        @(posedge clk); #1;

        // Out-of-range load must not alias
        load_en = 1'b1; load_addr = 16'd44; load_data = 40'hCC_CCCC_CCCC;
        @(posedge clk); #1;
        load_addr = 16'd300; load_data = 40'hDD_DDDD_DDDD;
        err_at[cyc + 1] = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0; pc = 16'd44;
        @(posedge clk);
        @(negedge clk);
        check("load_oor_keep", instr, 40'hCC_CCCC_CCCC);
        @(posedge clk); #1;

        // Software clear with a coincident write
        send(MEM_WRITE, 16'd9, 16'h1234);
        clear_start = 1'b1;
        send(MEM_WRITE, 16'd10, 16'hABCD);
        clear_start = 1'b0;
        zero_model();
        wait_clear("sw_clear");
        send(MEM_READ, 16'd9, '0);
        send(MEM_READ, 16'd10, '0);
        send(MEM_READ, 16'd5, '0);
        drain("sw_clear");

        // Reset during a pending read response
        send(MEM_WRITE, 16'd5, 16'h5A5A);
        bus.req_valid = 1'b1; bus.req_op = MEM_READ; bus.req_addr = 16'd5;
        @(negedge clk);
        check("rst_read_ready", bus.req_ready, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_read_rsp_valid", bus.rsp_valid, 0);
        check("rst_read_rdata", bus.rsp_rdata, 0);
        check("rst_read_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        zero_model();
        wait_clear("rst_read");

        // Reset in the middle of a clear
        send(MEM_WRITE, 16'd50, 16'h5555);
        send(MEM_WRITE, 16'd200, 16'h6666);
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midclr_busy", busy, 1);
        check("midclr_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        zero_model();
        wait_clear("midclr");
        read_all();
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
